horner_eval_core: RTL and testbench

Polynomial evaluation stage that computes p(x) = a_N·x^N + … + a_1·x + a_0 by Horner's rule, one coefficient per iteration. It sits directly downstream of the reset sequencer and consumes its active-low `rst` as its only reset. It reads coefficients from an upstream FIFO and writes one result word per evaluation into a downstream FIFO. All arithmetic is modulo 2^WIDTH.

---
 rtl/horner_eval_core.sv | 99 +++++++++
 tb/tb_horner_eval_core.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/horner_eval_core.sv
// Horner-rule polynomial evaluator: one coefficient per READ/WAIT pair, result written to a FIFO.
// Latency 2N+4 cycles from start to done with no stalls; empty/full flags stall READ/WRITE one cycle each.
module horner_eval_core #(
   parameter int WIDTH = 16,
   parameter int DEG_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DEG_W-1:0] degree,
   input  logic [WIDTH-1:0] x,
   input  logic             coef_empty,
   output logic             coef_rd_en,
   input  logic [WIDTH-1:0] coef_data,
   input  logic             res_full,
   output logic             res_wr_en,
   output logic [WIDTH-1:0] res_data,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WAIT  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] xr_q, xr_d;
   logic [DEG_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      xr_d    = xr_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               xr_d    = x;
               cnt_d   = degree;
               acc_d   = '0;
               state_d = S_READ;
            end
         end
         S_READ: begin
            if (!coef_empty) state_d = S_WAIT;
         end
         S_WAIT: begin
            // Truncating multiply-add: only the low WIDTH bits are ever needed.
            acc_d = acc_q * xr_q + coef_data;
            if (cnt_q == '0) begin
               state_d = S_WRITE;
            end else begin
               cnt_d   = cnt_q - DEG_W'(1);
               state_d = S_READ;
            end
         end
         S_WRITE: begin
            if (!res_full) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         xr_q    <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         xr_q    <= xr_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Strobes must react to the flags in the same cycle, so they are decoded rather than registered.
   assign coef_rd_en = (state_q == S_READ)  && !coef_empty;
   assign res_wr_en  = (state_q == S_WRITE) && !res_full;
   assign res_data   = acc_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_horner_eval_core.sv
// Directed bench for horner_eval_core with FIFO models and an expected-result scoreboard.
module tb_horner_eval_core;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  degree;
   logic [15:0] x;
   logic        coef_empty;
   logic        coef_rd_en;
   logic [15:0] coef_data;
   logic        res_full;
   logic        res_wr_en;
   logic [15:0] res_data;
   logic        busy;
   logic        done;

   horner_eval_core #(.WIDTH(16), .DEG_W(3)) dut (
      .clk(clk), .rst(rst), .start(start), .degree(degree), .x(x),
      .coef_empty(coef_empty), .coef_rd_en(coef_rd_en), .coef_data(coef_data),
      .res_full(res_full), .res_wr_en(res_wr_en), .res_data(res_data),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic [15:0] coef_q[$];
   logic [15:0] sb[$];
   int          rd_cyc[$];
   int          wr_cyc[$];
   int          done_cyc[$];
   logic        rd_pend;
   int          es_from = 0, es_len = 0;
   int          fs_from = 0, fs_len = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic upd_flags();
      coef_empty = (coef_q.size() == 0) || (cyc >= es_from && cyc < es_from + es_len);
      res_full   = (cyc >= fs_from && cyc < fs_from + fs_len);
   endtask

   // One clock: monitor at negedge, then advance FIFO models just after the rising edge.
   task automatic step();
      @(negedge clk);
      chk("no_rd_while_empty", {31'd0, coef_rd_en & coef_empty}, 32'd0);
      chk("no_wr_while_full", {31'd0, res_wr_en & res_full}, 32'd0);
      rd_pend = coef_rd_en;
      if (coef_rd_en) rd_cyc.push_back(cyc);
      if (res_wr_en) begin
         wr_cyc.push_back(cyc);
         if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
         else                chk("result", {16'd0, res_data}, {16'd0, sb.pop_front()});
      end
      if (done) done_cyc.push_back(cyc);
      @(posedge clk);
      #1;
      cyc++;
      if (rd_pend) coef_data = (coef_q.size() > 0) ? coef_q.pop_front() : 16'hBAD0;
      else         coef_data = 16'($urandom);
      upd_flags();
   endtask

   task automatic clear_logs();
      rd_cyc.delete();
      wr_cyc.delete();
      done_cyc.delete();
      cyc = 0;
   endtask

   task automatic run_eval(input string name, input int deg, input logic [15:0] xv,
                           input logic [15:0] exp_res, input int exp_wr, input int exp_done,
                           input int spulse);
      clear_logs();
      sb.push_back(exp_res);
      degree = 3'(deg);
      x      = xv;
      start  = 1'b1;
      upd_flags();
      chk({name, "_busy_idle"}, {31'd0, busy}, 32'd0);
      step();
      start = 1'b0;
      chk({name, "_busy_rise"}, {31'd0, busy}, 32'd1);
      while (done_cyc.size() == 0 && cyc < 80) begin
         start = (cyc == spulse);
         step();
      end
      start = 1'b0;
      chk({name, "_done_seen"}, done_cyc.size(), 32'd1);
      chk({name, "_wr_count"}, wr_cyc.size(), 32'd1);
      chk({name, "_wr_cycle"}, (wr_cyc.size() > 0) ? wr_cyc[0] : -1, exp_wr);
      chk({name, "_done_cycle"}, (done_cyc.size() > 0) ? done_cyc[0] : -1, exp_done);
      chk({name, "_rd_count"}, rd_cyc.size(), deg + 1);
      chk({name, "_sb_empty"}, sb.size(), 32'd0);
      chk({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
      chk({name, "_idle_done"}, {31'd0, done}, 32'd0);
      chk({name, "_res_hold"}, {16'd0, res_data}, {16'd0, exp_res});
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; degree = '0; x = '0; coef_data = '0;
      upd_flags();
      step(); step();
      chk("rst_rd_en", {31'd0, coef_rd_en}, 32'd0);
      chk("rst_wr_en", {31'd0, res_wr_en}, 32'd0);
      chk("rst_res_data", {16'd0, res_data}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      rst = 1'b1;
      step();

      // Basic: 2x^2 + x + 5 at x=3 -> 26
      coef_q = '{16'd2, 16'd1, 16'd5};
      run_eval("basic", 2, 16'd3, 16'd26, 7, 8, -1);
      for (int k = 0; k < 3; k++)
         chk("basic_rd_cycle", (rd_cyc.size() > k) ? rd_cyc[k] : -1, 2 * k + 1);

      coef_q = '{16'h1234};
      run_eval("deg0", 0, 16'hFFFF, 16'h1234, 3, 4, -1);

      coef_q = '{16'd1, 16'd0, 16'd7};
      run_eval("wrap2", 2, 16'h0100, 16'h0007, 7, 8, -1);

      coef_q = '{16'd1, 16'd1};
      run_eval("wrap1", 1, 16'hFFFF, 16'h0000, 5, 6, -1);

      // Back-pressure on the basic case
      es_from = 3; es_len = 3; fs_from = 10; fs_len = 2;
      coef_q = '{16'd2, 16'd1, 16'd5};
      run_eval("bp", 2, 16'd3, 16'd26, 12, 13, -1);
      chk("bp_rd_cycle1", (rd_cyc.size() > 1) ? rd_cyc[1] : -1, 6);
      es_len = 0; fs_len = 0;
      upd_flags();

      // Start pulsed while busy has no effect
      coef_q = '{16'd2, 16'd1, 16'd5};
      run_eval("ign_start", 2, 16'd3, 16'd26, 7, 8, 3);
      repeat (3) step();
      chk("ign_start_no_rd", rd_cyc.size(), 32'd3);

      // Reset during the first WAIT
      clear_logs();
      coef_q = '{16'd2, 16'd1, 16'd5};
      degree = 3'd2; x = 16'd3; start = 1'b1;
      upd_flags();
      step();
      start = 1'b0;
      step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("mrst_busy", {31'd0, busy}, 32'd0);
      chk("mrst_done", {31'd0, done}, 32'd0);
      chk("mrst_rd_en", {31'd0, coef_rd_en}, 32'd0);
      chk("mrst_wr_en", {31'd0, res_wr_en}, 32'd0);
      chk("mrst_res_data", {16'd0, res_data}, 32'd0);
      repeat (6) step();
      chk("mrst_no_wr", wr_cyc.size(), 32'd0);
      chk("mrst_no_done", done_cyc.size(), 32'd0);
      chk("mrst_rd_count", rd_cyc.size(), 32'd1);
      coef_q.delete();
      upd_flags();

      // Back-to-back with start held: (x+1)@2 = 3, (3x+4)@2 = 10
      clear_logs();
      coef_q = '{16'd1, 16'd1, 16'd3, 16'd4};
      sb.push_back(16'd3);
      sb.push_back(16'd10);
      degree = 3'd1; x = 16'd2; start = 1'b1;
      upd_flags();
      while (done_cyc.size() < 2 && cyc < 80) begin
         if (cyc == 8) start = 1'b0;
         step();
      end
      start = 1'b0;
      chk("b2b_done_count", done_cyc.size(), 32'd2);
      chk("b2b_wr0", (wr_cyc.size() > 0) ? wr_cyc[0] : -1, 5);
      chk("b2b_wr1", (wr_cyc.size() > 1) ? wr_cyc[1] : -1, 12);
      chk("b2b_done0", (done_cyc.size() > 0) ? done_cyc[0] : -1, 6);
      chk("b2b_done1", (done_cyc.size() > 1) ? done_cyc[1] : -1, 13);
      chk("b2b_second_read", (rd_cyc.size() > 2) ? rd_cyc[2] : -1, 8);
      chk("b2b_sb_empty", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
